// File: rtl/cv32e40x_xif_result_buffer_if.sv
// Handshake bundle between the AES FU, the core commit interface and the XIF result channel.
// master drives FU results, commits and result_ready; slave is the result buffer.
interface cv32e40x_xif_result_buffer_if #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_RFW_WIDTH = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                   fu_valid;
  logic                   fu_ready;
  logic [X_ID_WIDTH-1:0]  fu_id;
  logic [X_RFW_WIDTH-1:0] fu_data;
  logic [4:0]             fu_rd;
  logic                   fu_we;

  logic                   commit_valid;
  logic [X_ID_WIDTH-1:0]  commit_id;
  logic                   commit_kill;

  logic                   result_valid;
  logic                   result_ready;
  logic [X_ID_WIDTH-1:0]  result_id;
  logic [X_RFW_WIDTH-1:0] result_data;
  logic [4:0]             result_rd;
  logic                   result_we;

  logic [CNT_W-1:0]       count;

  modport master (
    output fu_valid, fu_id, fu_data, fu_rd, fu_we,
    output commit_valid, commit_id, commit_kill,
    output result_ready,
    input  fu_ready, result_valid, result_id, result_data, result_rd, result_we, count
  );

  modport slave (
    input  fu_valid, fu_id, fu_data, fu_rd, fu_we,
    input  commit_valid, commit_id, commit_kill,
    input  result_ready,
    output fu_ready, result_valid, result_id, result_data, result_rd, result_we, count
  );
endinterface

// File: rtl/cv32e40x_xif_result_buffer.sv
// In-order result FIFO between the AES FU and the XIF result channel; holds each result
// until its ID is committed (then presented) or killed (then silently dropped).
module cv32e40x_xif_result_buffer #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_RFW_WIDTH = 32
) (
  input logic                            clk,
  input logic                            rst,
  cv32e40x_xif_result_buffer_if.slave    bus
);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned NUM_IDS = 2 ** X_ID_WIDTH;

  typedef enum logic [1:0] {
    HEAD_WAIT = 2'd0,
    HEAD_SEND = 2'd1,
    HEAD_DROP = 2'd2
  } head_state_e;

  logic [X_ID_WIDTH-1:0]  ent_id   [DEPTH];
  logic [X_RFW_WIDTH-1:0] ent_data [DEPTH];
  logic [4:0]             ent_rd   [DEPTH];
  logic                   ent_we   [DEPTH];
  logic                   ent_vld  [DEPTH];
  logic                   ent_cmt  [DEPTH];
  logic                   ent_kill [DEPTH];

  logic                   cmt_seen [NUM_IDS];
  logic                   cmt_kill [NUM_IDS];

  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count_q;

  head_state_e            head_state;
  logic [X_ID_WIDTH-1:0]  head_id;
  logic                   ready_int;
  logic                   push;
  logic                   pop;
  logic                   commit_new;
  logic                   push_cmt;
  logic                   push_kill;

  // Head decode: the head entry's commit flags alone choose wait/present/drop.
  always_comb begin
    head_state = HEAD_WAIT;
    head_id    = ent_id[rd_ptr];
    if ((count_q != '0) && ent_cmt[rd_ptr]) begin
      head_state = ent_kill[rd_ptr] ? HEAD_DROP : HEAD_SEND;
    end
  end

  // Handshake qualifiers and commit flags for the entry being written this cycle.
  always_comb begin
    ready_int  = (count_q != CNT_W'(DEPTH));
    push       = bus.fu_valid && ready_int;
    pop        = ((head_state == HEAD_SEND) && bus.result_ready) || (head_state == HEAD_DROP);
    commit_new = bus.commit_valid && !cmt_seen[bus.commit_id];
    push_cmt   = cmt_seen[bus.fu_id];
    push_kill  = cmt_kill[bus.fu_id];
    if (commit_new && (bus.commit_id == bus.fu_id)) begin
      push_cmt  = 1'b1;
      push_kill = bus.commit_kill;
    end else if (pop && (head_id == bus.fu_id)) begin
      // The head's ID is being released on this edge, so a reuse starts uncommitted.
      push_cmt  = 1'b0;
      push_kill = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_id[i]   <= '0;
        ent_data[i] <= '0;
        ent_rd[i]   <= '0;
        ent_we[i]   <= 1'b0;
        ent_vld[i]  <= 1'b0;
        ent_cmt[i]  <= 1'b0;
        ent_kill[i] <= 1'b0;
      end
      for (int j = 0; j < int'(NUM_IDS); j++) begin
        cmt_seen[j] <= 1'b0;
        cmt_kill[j] <= 1'b0;
      end
    end else begin
      if (pop) begin
        cmt_seen[head_id] <= 1'b0;
        cmt_kill[head_id] <= 1'b0;
        ent_vld[rd_ptr]   <= 1'b0;
        rd_ptr            <= rd_ptr + PTR_W'(1);
      end
      if (commit_new) begin
        cmt_seen[bus.commit_id] <= 1'b1;
        cmt_kill[bus.commit_id] <= bus.commit_kill;
      end
      // Late commits resolve entries already queued under that ID.
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (commit_new && ent_vld[i] && !ent_cmt[i] && (ent_id[i] == bus.commit_id)) begin
          ent_cmt[i]  <= 1'b1;
          ent_kill[i] <= bus.commit_kill;
        end
      end
      if (push) begin
        ent_id[wr_ptr]   <= bus.fu_id;
        ent_data[wr_ptr] <= bus.fu_data;
        ent_rd[wr_ptr]   <= bus.fu_rd;
        ent_we[wr_ptr]   <= bus.fu_we;
        ent_vld[wr_ptr]  <= 1'b1;
        ent_cmt[wr_ptr]  <= push_cmt;
        ent_kill[wr_ptr] <= push_kill;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Outputs come only from state; payload is zeroed unless presenting, so killed data never leaks.
  assign bus.fu_ready     = ready_int;
  assign bus.count        = count_q;
  assign bus.result_valid = (head_state == HEAD_SEND);
  assign bus.result_id    = (head_state == HEAD_SEND) ? ent_id[rd_ptr]   : '0;
  assign bus.result_data  = (head_state == HEAD_SEND) ? ent_data[rd_ptr] : '0;
  assign bus.result_rd    = (head_state == HEAD_SEND) ? ent_rd[rd_ptr]   : '0;
  assign bus.result_we    = (head_state == HEAD_SEND) ? ent_we[rd_ptr]   : 1'b0;

endmodule

// File: tb/tb_cv32e40x_xif_result_buffer.sv
// Scoreboard bench for the XIF result buffer: directed stimulus queues expected results,
// a negedge monitor checks every result handshake against the queue.
module tb_cv32e40x_xif_result_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDW   = 4;
  localparam int unsigned RFW   = 32;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [RFW-1:0] data;
    logic [4:0]     rd;
    logic           we;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  exp_t exp_q[$];

  cv32e40x_xif_result_buffer_if #(.DEPTH(DEPTH), .X_ID_WIDTH(IDW), .X_RFW_WIDTH(RFW)) bus ();

  cv32e40x_xif_result_buffer #(.DEPTH(DEPTH), .X_ID_WIDTH(IDW), .X_RFW_WIDTH(RFW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [IDW-1:0] id, input logic [RFW-1:0] data,
                      input logic [4:0] rd, input logic we, input bit expect_out);
    exp_t e;
    bus.fu_valid = 1'b1;
    bus.fu_id    = id;
    bus.fu_data  = data;
    bus.fu_rd    = rd;
    bus.fu_we    = we;
    if (expect_out) begin
      e = '{id: id, data: data, rd: rd, we: we};
      exp_q.push_back(e);
    end
    tick();
    bus.fu_valid = 1'b0;
  endtask

  task automatic commit(input logic [IDW-1:0] id, input logic kill);
    bus.commit_valid = 1'b1;
    bus.commit_id    = id;
    bus.commit_kill  = kill;
    tick();
    bus.commit_valid = 1'b0;
    bus.commit_kill  = 1'b0;
  endtask

  // Monitor: a handshake seen at negedge is consumed by the following posedge.
  always @(negedge clk) begin
    exp_t act;
    exp_t req;
    if (!rst && bus.result_valid && bus.result_ready) begin
      act = '{id: bus.result_id, data: bus.result_data, rd: bus.result_rd, we: bus.result_we};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_result: got id=%0d data=0x%0h required no output", act.id, act.data);
      end else begin
        req = exp_q.pop_front();
        if (act === req) n_pass++;
        else $display("FAIL result_payload: got id=%0d data=0x%0h rd=%0d we=%0b required id=%0d data=0x%0h rd=%0d we=%0b",
                      act.id, act.data, act.rd, act.we, req.id, req.data, req.rd, req.we);
      end
    end
  end

  initial begin
    n_checks         = 0;
    n_pass           = 0;
    rst              = 1'b1;
    bus.fu_valid     = 1'b0;
    bus.fu_id        = '0;
    bus.fu_data      = '0;
    bus.fu_rd        = '0;
    bus.fu_we        = 1'b0;
    bus.commit_valid = 1'b0;
    bus.commit_id    = '0;
    bus.commit_kill  = 1'b0;
    bus.result_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_valid", 32'(bus.result_valid), 32'd0);
    check("rst_fu_ready", 32'(bus.fu_ready), 32'd1);
    check("rst_result_id", 32'(bus.result_id), 32'd0);
    check("rst_result_data", bus.result_data, 32'd0);
    check("rst_result_rd", 32'(bus.result_rd), 32'd0);

    // Commit before result
    commit(4'd3, 1'b0);
    push(4'd3, 32'hA5A5_0001, 5'd5, 1'b1, 1'b1);
    check("cbr_valid", 32'(bus.result_valid), 32'd1);
    check("cbr_id", 32'(bus.result_id), 32'd3);
    check("cbr_data", bus.result_data, 32'hA5A5_0001);
    check("cbr_rd", 32'(bus.result_rd), 32'd5);
    check("cbr_count", 32'(bus.count), 32'd1);
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    check("cbr_count_after", 32'(bus.count), 32'd0);

    // Result before commit, with output stall
    push(4'd2, 32'h1234_5678, 5'd7, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("rbc_wait_valid", 32'(bus.result_valid), 32'd0);
      tick();
    end
    commit(4'd2, 1'b0);
    check("rbc_valid", 32'(bus.result_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rbc_stall_valid", 32'(bus.result_valid), 32'd1);
      check("rbc_stall_data", bus.result_data, 32'h1234_5678);
    end
    check("rbc_count_before", 32'(bus.count), 32'd1);
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    check("rbc_count_after", 32'(bus.count), 32'd0);

    // Kill drop
    push(4'd1, 32'h0000_0011, 5'd1, 1'b1, 1'b0);
    push(4'd2, 32'h0000_0022, 5'd2, 1'b0, 1'b1);
    check("kill_count2", 32'(bus.count), 32'd2);
    commit(4'd1, 1'b1);
    check("kill_drop_valid", 32'(bus.result_valid), 32'd0);
    check("kill_drop_count", 32'(bus.count), 32'd2);
    commit(4'd2, 1'b0);
    check("kill_count1", 32'(bus.count), 32'd1);
    check("kill_valid2", 32'(bus.result_valid), 32'd1);
    check("kill_id2", 32'(bus.result_id), 32'd2);
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    check("kill_count0", 32'(bus.count), 32'd0);

    // Full and backpressure
    for (int k = 0; k < 4; k++) commit(4'(k), 1'b0);
    for (int k = 0; k < 4; k++) push(4'(k), 32'hF0 + 32'(k), 5'(k + 1), 1'(k % 2), 1'b1);
    check("full_count", 32'(bus.count), 32'd4);
    check("full_fu_ready", 32'(bus.fu_ready), 32'd0);
    push(4'd5, 32'hDEAD_BEEF, 5'd9, 1'b1, 1'b0);
    check("full_ignored_count", 32'(bus.count), 32'd4);
    bus.result_ready = 1'b1;
    tick();
    check("full_pop1_count", 32'(bus.count), 32'd3);
    check("full_pop1_fu_ready", 32'(bus.fu_ready), 32'd1);
    tick();
    tick();
    tick();
    bus.result_ready = 1'b0;
    check("full_drain_count", 32'(bus.count), 32'd0);

    // Streaming with wrap: push and pop each cycle
    for (int k = 0; k < 10; k++) commit(4'(4 + k), 1'b0);
    bus.result_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push(4'(4 + k), 32'hC0DE_0000 + 32'(k), 5'(10 + k), 1'b1, 1'b1);
      check("stream_count", 32'(bus.count), 32'd1);
    end
    tick();
    bus.result_ready = 1'b0;
    check("stream_drain_count", 32'(bus.count), 32'd0);

    // Reset mid-operation
    commit(4'd9, 1'b0);
    push(4'd9, 32'h0000_0909, 5'd3, 1'b1, 1'b0);
    push(4'd10, 32'h0000_0A0A, 5'd4, 1'b1, 1'b0);
    push(4'd11, 32'h0000_0B0B, 5'd6, 1'b0, 1'b0);
    check("mid_count3", 32'(bus.count), 32'd3);
    check("mid_valid", 32'(bus.result_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_valid", 32'(bus.result_valid), 32'd0);
    check("mid_rst_fu_ready", 32'(bus.fu_ready), 32'd1);
    check("mid_rst_id", 32'(bus.result_id), 32'd0);
    push(4'd9, 32'h0000_9999, 5'd8, 1'b1, 1'b1);
    tick();
    check("mid_repush_needs_commit", 32'(bus.result_valid), 32'd0);
    commit(4'd9, 1'b0);
    check("mid_recommit_valid", 32'(bus.result_valid), 32'd1);
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    check("mid_final_count", 32'(bus.count), 32'd0);

    tick();
    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cv32e40x_xif_result_buffer.md
Name: cv32e40x_xif_result_buffer

Overview:
- Sits directly downstream of the AES coprocessor functional unit and upstream of the core's XIF result interface.
- Buffers FU results in issue order and holds each one until the core's commit interface resolves its instruction ID.
- Committed results are presented on the XIF result channel. Killed results are discarded silently.
- This lets the FU accept new work before commit arrives and keeps kill handling out of the FU.

Parameters:
- DEPTH, 4: number of result entries; power of two, at least 2.
- X_ID_WIDTH, 4: width of the instruction ID.
- X_RFW_WIDTH, 32: width of the result data.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fu_valid  in  1  FU presents a result.
- fu_ready  out  1  buffer can accept; equals !full.
- fu_id  in  X_ID_WIDTH  ID of the FU result.
- fu_data  in  X_RFW_WIDTH  result data.
- fu_rd  in  5  destination register address.
- fu_we  in  1  register write enable.
- commit_valid  in  1  commit interface valid.
- commit_id  in  X_ID_WIDTH  ID being committed or killed.
- commit_kill  in  1  1 = kill, 0 = commit.
- result_valid  out  1  XIF result valid.
- result_ready  in  1  XIF result ready.
- result_id  out  X_ID_WIDTH  head entry ID.
- result_data  out  X_RFW_WIDTH  head entry data.
- result_rd  out  5  head entry rd.
- result_we  out  1  head entry we.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (rst=1 at an edge) clears all state, in any state:
  - all entries, pointers and count.
  - the commit table (cmt_seen and cmt_kill for all 2^X_ID_WIDTH IDs).
  - After reset: result_valid=0, fu_ready=1, count=0, and result_id/result_data/result_rd/result_we are 0.
  - Any result in flight at reset is lost; no output is produced for it.
- Storage is a circular FIFO: wr_ptr and rd_ptr wrap modulo DEPTH; count runs from 0 to DEPTH.
- Push occurs when fu_valid && fu_ready.
  - The entry is written at wr_ptr with {id, data, rd, we}.
  - The entry's committed/killed flags are loaded from cmt_seen[fu_id] and cmt_kill[fu_id].
  - If commit_valid with commit_id==fu_id occurs in the same cycle, the flags take the new commit value.
- Commit table:
  - On commit_valid, set cmt_seen[commit_id]=1 and cmt_kill[commit_id]=commit_kill.
  - Every valid, non-committed entry with a matching id also updates its flags in the same edge.
  - A second commit for an already-seen ID is ignored.
- Head state, with the head entry valid when count>0:
  - WAIT: head not committed. result_valid=0.
  - SEND: head committed and not killed. result_valid=1.
    - Pop on result_ready.
    - Outputs stay stable until popped.
  - DROP: head committed and killed. result_valid=0.
    - The head is popped unconditionally in that cycle.
    - At most one drop per cycle.
- On pop or drop, clear cmt_seen and cmt_kill for the head ID so the ID can be reused.
- Latency:
  - A pushed entry whose commit was seen earlier reaches the head with result_valid=1 at the next edge.
  - If the commit arrives later, result_valid rises the edge after commit_valid.
  - There is no combinational path from fu_* or commit_* to result_*.
- Full: count==DEPTH, fu_ready=0, fu_valid is ignored.
  - fu_ready depends only on registered count, never on result_ready.
- Empty: count==0, result_valid=0.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- result_we is passed through from fu_we unmodified. The data of killed entries is never exposed.

Test Plan:
- Commit before result: commit id=3 (kill=0), then push id=3 data=32'hA5A5_0001 rd=5 → result_valid=1 one cycle after the push, with result_id=3, result_data=32'hA5A5_0001, result_rd=5.
- Result before commit: push id=2, hold 4 idle cycles (result_valid stays 0), then commit id=2 → result_valid=1 on the next cycle. With result_ready=0 for 3 cycles the outputs stay stable, and count goes 1→0 on the ready handshake.
- Kill drop: push ids 1 and 2, kill id=1, commit id=2, result_ready=1 → id 1 is never presented. id 2 appears exactly once, and count goes 2→1→0.
- Full/backpressure: commit ids 0–3, then push ids 0–3 with result_ready=0 → count=4, fu_ready=0, and a 5th fu_valid is ignored. With result_ready=1, one pop per cycle returns ids in order 0,1,2,3; fu_ready returns to 1 after the first pop.
- Wrap and simultaneous push/pop: stream 10 committed results with fu_valid and result_ready held at 1 → each is output in order, count stays at 1 in steady state, and the pointers wrap correctly past DEPTH.
- Reset mid-operation: with 3 entries queued (one committed) assert rst for 1 cycle → the following cycle shows count=0, result_valid=0, fu_ready=1, and the old IDs pushed again require a fresh commit.
